mips_multdiv_unit: RTL and testbench
====================================

# mips_multdiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the Harvard MIPS CPU datapath. It sits downstream of the register file: it consumes the rs/rt read values and the decoded mult/div/mthi/mtlo operation. Its registered HI/LO outputs feed the writeback mux for MFHI/MFLO. Its `busy` output drives the datapath stall so that the PC register and register file hold while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled low on a rising edge → reset.
- `start`  in  1  operation request, qualified by `!busy`.
- `op`  in  3  `multdiv_op_t`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a`  in  WIDTH  rs value (dividend / multiplicand / MTHI/MTLO source).
- `b`  in  WIDTH  rt value (divisor / multiplier).
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  high while state ≠ IDLE; the CPU stalls on it.
- `done`  out  1  one-cycle pulse when HI/LO take a new mult/div result.

## Operation
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE, iteration counter=0.
- **States:**
  - IDLE: on `start` with MULT/MULTU/DIV/DIVU, latch operand magnitudes and sign flags and go to RUN.
  - RUN: 32 iterations, one per cycle. MULT uses shift-add; DIV uses restoring shift-subtract. The counter runs 0..31 and goes to FIN after count 31.
  - FIN: apply sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
- **MTHI/MTLO:** accepted in IDLE only. Writes `a` into `hi`/`lo` at the sampling edge. No `busy`, no `done`.
- **Start handling:** `start` while busy is ignored with no effect on the running op. `start` is accepted in the cycle `done` is high, because the unit is already IDLE.
- **Multiply:**
  - Full 64-bit product; `hi` = [63:32], `lo` = [31:0].
  - Signed mult works on magnitudes; the product is negated if the operand signs differ.
- **Divide:**
  - `lo` = quotient, `hi` = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - Divide by zero (signed or unsigned): `hi`=`a`, `lo`=0xFFFFFFFF. The op still takes the full latency.
- **Hold during operation:** `hi`/`lo` keep their previous values throughout RUN; partial results are never visible.
- **Reset mid-operation:** the operation is aborted. The next cycle shows all reset values.

## Timing
- `start` sampled at edge N (iterative path):
  - `busy`=1 in the cycles following edges N..N+32.
  - Results are written at edge N+33; `done`=1 and the new `hi`/`lo` are visible in the cycle following edge N+33.
- MTHI/MTLO: new value visible in the cycle following the sampling edge.
- `done` is never high for more than one cycle, and never high together with `busy`.

## Configuration
- `MULTDIV_FAST_MULT_EN`:
  - **Defined:** MULT/MULTU use a combinational 64-bit multiplier. The result is written at sampling edge N, `done`=1 in the cycle after N, and `busy` never rises. DIV is unchanged.
  - **Undefined:** MULT/MULTU use the 32-iteration path with the same latency as DIV.

## Structure
- Package `mips_multdiv_pkg` holds:
  - `multdiv_op_t` enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 are no-ops.
  - `multdiv_state_t` enum: IDLE, RUN, FIN.
  - Constant `MULTDIV_ITERS`=32.
- Sub-module `multdiv_step`: combinational single iteration for either shift-add or restoring-subtract.
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator and next quotient/product bit.
  - The top module instantiates it once and holds all FSM/counter state.

## Test plan
1. Without the macro: MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` in the cycle after edge N+33, `busy` for exactly 33 cycles.
2. MULT 0xFFFFFFFD×0x00000007 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. With the macro, the same result with `done` in the cycle after N and `busy` never high.
3. DIV 0xFFFFFFF9/0x00000002 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1.
4. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU 5/0 → `hi`=5, `lo`=0xFFFFFFFF.
5. Start DIVU 100/7, then:
   - pulse `start` with MTHI 0xDEADBEEF at iteration 5 → ignored; final `lo`=14, `hi`=2;
   - in a second run, drive `reset` low at iteration 10 → next cycle `hi`=`lo`=0, `busy`=0, `done`=0.
6. MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive edges → each visible one cycle later, `done` stays 0. A back-to-back MULTU issued in the `done` cycle is accepted.

Source files
------------

// File: rtl/mips_multdiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_multdiv_pkg;

   // Decoded HI/LO operation; encodings 6 and 7 do nothing.
   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5,
      NOP6  = 3'd6,
      NOP7  = 3'd7
   } multdiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } multdiv_state_t;

   // Selects shift-add (multiply) or restoring shift-subtract (divide) in one iteration.
   typedef enum logic {
      StepMul = 1'b0,
      StepDiv = 1'b1
   } step_mode_t;

   localparam int unsigned MULTDIV_ITERS = 32;
   localparam int unsigned MULTDIV_CNT_W = $clog2(MULTDIV_ITERS);

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: acc_i is the upper product half, bit_i the current multiplier LSB; bit_o is the bit
// that shifts into the top of the lower product half.
// Divide: acc_i is the partial remainder, bit_i the next dividend bit; bit_o is the quotient bit.
module multdiv_step
   import mips_multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] operand_i,
   input  logic             bit_i,
   input  step_mode_t       mode_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             bit_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Compute both candidate iterations and pick the one for the active mode.
   always_comb begin
      sum     = {1'b0, acc_i} + (bit_i ? {1'b0, operand_i} : {(WIDTH + 1){1'b0}});
      shifted = {acc_i, bit_i};
      diff    = shifted - {1'b0, operand_i};
      acc_o   = sum[WIDTH:1];
      bit_o   = sum[0];
      if (mode_i == StepDiv) begin
         // Remainder stays below the divisor, so a clear top bit means no borrow.
         if (!diff[WIDTH]) begin
            acc_o = diff[WIDTH-1:0];
            bit_o = 1'b1;
         end else begin
            acc_o = shifted[WIDTH-1:0];
            bit_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mips_multdiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional build macro: MULTDIV_FAST_MULT_EN selects a single-cycle combinational multiplier
// for MULT/MULTU; divides always take the iterative path.
module mips_multdiv_unit
   import mips_multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  multdiv_op_t      op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [MULTDIV_CNT_W-1:0] LastCnt = MULTDIV_CNT_W'(MULTDIV_ITERS - 1);

   multdiv_state_t           state_q;
   logic [MULTDIV_CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0]         acc_q, low_q, opnd_q;
   step_mode_t               mode_q;
   logic                     neg_q, rem_neg_q, dbz_q;
   logic [WIDTH-1:0]         hi_q, lo_q;
   logic                     done_q;

   logic             div_op, mul_op, iter_op, is_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             step_bit_in, step_bit_out;
   logic [WIDTH-1:0] step_acc, low_d;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quot, rem, fin_hi, fin_lo;

   // Decode the request and form operand magnitudes and sign flags.
   always_comb begin
      div_op    = (op == DIV) || (op == DIVU);
      mul_op    = (op == MULT) || (op == MULTU);
`ifdef MULTDIV_FAST_MULT_EN
      iter_op   = div_op;
`else
      iter_op   = div_op || mul_op;
`endif
      is_signed = (op == MULT) || (op == DIV);
      a_neg     = is_signed && a[WIDTH-1];
      b_neg     = is_signed && b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
   end

`ifdef MULTDIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;

   // Sign- or zero-extend so the low 2*WIDTH product bits are exact for either signedness.
   always_comb begin
      a_ext     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      b_ext     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      fast_prod = a_ext * b_ext;
   end
`endif

   // Multiply shifts the low half right (LSB is the multiplier bit); divide shifts it left.
   always_comb begin
      step_bit_in = (mode_q == StepDiv) ? low_q[WIDTH-1] : low_q[0];
      low_d       = (mode_q == StepDiv) ? {low_q[WIDTH-2:0], step_bit_out}
                                        : {step_bit_out, low_q[WIDTH-1:1]};
   end

   multdiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .bit_i     (step_bit_in),
      .mode_i    (mode_q),
      .acc_o     (step_acc),
      .bit_o     (step_bit_out)
   );

   // Sign correction of the finished magnitude result.
   always_comb begin
      prod     = {acc_q, low_q};
      prod_fix = neg_q ? -prod : prod;
      quot     = neg_q ? -low_q : low_q;
      rem      = rem_neg_q ? -acc_q : acc_q;
      fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo   = prod_fix[WIDTH-1:0];
      if (mode_q == StepDiv) begin
         // Divide by zero leaves the dividend in the remainder; quotient is forced to all ones.
         fin_hi = rem;
         fin_lo = dbz_q ? {WIDTH{1'b1}} : quot;
      end
   end

   // Control FSM, iteration datapath and HI/LO architectural state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         low_q     <= '0;
         opnd_q    <= '0;
         mode_q    <= StepMul;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (iter_op) begin
                     state_q   <= RUN;
                     cnt_q     <= '0;
                     acc_q     <= '0;
                     mode_q    <= div_op ? StepDiv : StepMul;
                     low_q     <= div_op ? a_mag : b_mag;
                     opnd_q    <= div_op ? b_mag : a_mag;
                     neg_q     <= a_neg ^ b_neg;
                     rem_neg_q <= a_neg;
                     dbz_q     <= div_op && (b == '0);
                  end else if (op == MTHI) begin
                     hi_q <= a;
                  end else if (op == MTLO) begin
                     lo_q <= a;
`ifdef MULTDIV_FAST_MULT_EN
                  end else if (mul_op) begin
                     hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                     lo_q   <= fast_prod[WIDTH-1:0];
                     done_q <= 1'b1;
`endif
                  end
               end
            end
            RUN: begin
               acc_q <= step_acc;
               low_q <= low_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  state_q <= FIN;
               end
            end
            FIN: begin
               hi_q    <= fin_hi;
               lo_q    <= fin_lo;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_mips_multdiv_unit.sv
// Self-checking bench for mips_multdiv_unit; honours MULTDIV_FAST_MULT_EN for multiply latency.
module tb_mips_multdiv_unit;
   import mips_multdiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   multdiv_op_t op = MULT;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int tests = 0;
   int fails = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mips_multdiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Architectural result from plain integer arithmetic.
   function automatic void model(input multdiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      eh = m_hi;
      el = m_lo;
      case (o)
         MULT: begin
            p  = 64'(sx * sy);
            eh = p[63:32];
            el = p[31:0];
         end
         MULTU: begin
            p  = {32'b0, x} * {32'b0, y};
            eh = p[63:32];
            el = p[31:0];
         end
         DIV: begin
            if (y == 0) begin
               eh = x;
               el = 32'hFFFF_FFFF;
            end else begin
               q  = sx / sy;
               r  = sx % sy;
               eh = r[31:0];
               el = q[31:0];
            end
         end
         DIVU: begin
            if (y == 0) begin
               eh = x;
               el = 32'hFFFF_FFFF;
            end else begin
               eh = x % y;
               el = x / y;
            end
         end
         MTHI: eh = x;
         MTLO: el = x;
         default: ;
      endcase
   endfunction

   // Issue one mult/div op; returns in the done cycle (or after a timeout).
   task automatic run_op(input multdiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                         input string nm);
      logic [31:0] eh, el;
      int exp_lat, busy_cnt, done_at;
      bit hold_ok, overlap;
      model(o, x, y, eh, el);
      exp_lat = 33;
`ifdef MULTDIV_FAST_MULT_EN
      if (o == MULT || o == MULTU) exp_lat = 0;
`endif
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      busy_cnt = 0; done_at = -1; hold_ok = 1'b1; overlap = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy) busy_cnt++;
         if (busy && done) overlap = 1'b1;
         if (done) begin
            done_at = k;
            break;
         end
         if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
         @(posedge clk); #1;
      end
      tests++;
      if (done_at !== exp_lat) begin
         fails++;
         $display("FAIL %s done_cycle: got %0d expected %0d", nm, done_at, exp_lat);
      end
      tests++;
      if (busy_cnt !== exp_lat) begin
         fails++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy_cnt, exp_lat);
      end
      tests++;
      if (hi !== eh) begin
         fails++;
         $display("FAIL %s hi: got %h expected %h", nm, hi, eh);
      end
      tests++;
      if (lo !== el) begin
         fails++;
         $display("FAIL %s lo: got %h expected %h", nm, lo, el);
      end
      tests++;
      if (!hold_ok) begin
         fails++;
         $display("FAIL %s hold: hi/lo changed before done (old %h/%h)", nm, m_hi, m_lo);
      end
      tests++;
      if (overlap) begin
         fails++;
         $display("FAIL %s overlap: busy and done high together", nm);
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({hi, lo, busy, done} !== 66'b0) begin
         fails++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
      end
      @(negedge clk);
      reset = 1'b1;
      m_hi = '0;
      m_lo = '0;
   endtask

   task automatic test_mult();
      multdiv_op_t o;
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      run_op(MULT, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
      run_op(MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
      for (int i = 0; i < 6; i++) begin
         o = multdiv_op_t'($urandom_range(0, 1));
         run_op(o, $urandom(), $urandom(), "mult_rand");
      end
   endtask

   task automatic test_div();
      multdiv_op_t o;
      logic [31:0] y;
      run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
      run_op(DIVU, 32'd7, 32'd2, "divu_small");
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(DIVU, 32'd5, 32'd0, "divu_zero");
      run_op(DIV, 32'hFFFF_FF00, 32'd0, "div_zero_neg");
      run_op(DIV, 32'd17, 32'hFFFF_FFFB, "div_negdivisor");
      for (int i = 0; i < 8; i++) begin
         o = multdiv_op_t'($urandom_range(2, 3));
         y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
         run_op(o, $urandom(), y, "div_rand");
      end
   endtask

   task automatic test_start_ignored();
      int done_at;
      @(negedge clk);
      start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0;
      done_at = -1;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            done_at = k;
            break;
         end
         @(posedge clk); #1;
      end
      tests++;
      if (done_at < 0) begin
         fails++;
         $display("FAIL ignore_done: got no done within 40 cycles, expected done");
      end
      tests++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         fails++;
         $display("FAIL ignore_result: got hi=%h lo=%h expected hi=2 lo=14", hi, lo);
      end
      m_hi = 32'd2;
      m_lo = 32'd14;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1; op = MTHI; a = 32'hA5A5_0001;
      @(negedge clk);
      op = MTLO; a = 32'h5A5A_0002;
      @(negedge clk);
      op = DIVU; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ({hi, lo, busy, done} !== 66'b0) begin
         fails++;
         $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b expected all zero",
                  hi, lo, busy, done);
      end
      @(negedge clk);
      reset = 1'b1;
      m_hi = '0;
      m_lo = '0;
      run_op(DIVU, 32'd100, 32'd7, "divu_after_reset");
   endtask

   task automatic test_mthi_mtlo();
      @(negedge clk);
      start = 1'b1; op = MTHI; a = 32'h1234_5678;
      @(posedge clk); #1;
      tests++;
      if (hi !== 32'h1234_5678 || done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mthi: got hi=%h done=%b busy=%b expected 12345678/0/0", hi, done, busy);
      end
      @(negedge clk);
      op = MTLO; a = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mtlo: got hi=%h lo=%h done=%b busy=%b expected 12345678/9abcdef0/0/0",
                  hi, lo, done, busy);
      end
      m_hi = 32'h1234_5678;
      m_lo = 32'h9ABC_DEF0;
   endtask

   task automatic test_back_to_back();
      run_op(MULTU, $urandom(), $urandom(), "b2b_first");
      // run_op returns in the done cycle, so this start lands while done is high.
      run_op(MULTU, $urandom(), $urandom(), "b2b_second");
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse: got done=%b one cycle later, expected 0", done);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_start_ignored();
      test_reset_mid();
      test_mthi_mtlo();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
